// File: rtl/lab5_pkg.sv
// rtl/lab5_pkg.sv - shared parameters and occupancy state type for fifo_drain
//
// Purpose: default widths and the skid-buffer occupancy enum used by fifo_drain.
// Ports: none (package).

package lab5_pkg;

    localparam int DATA_WIDTH_DEF = 24;
    localparam int CNT_WIDTH_DEF  = 16;

    // Number of words currently held in the two-entry skid buffer.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } occ_state_t;

endpackage : lab5_pkg

// File: rtl/fifo_drain.sv
// rtl/fifo_drain.sv - drains a FWFT FIFO into a ready/valid stream via a 2-entry skid buffer
//
// Purpose: pops words from an upstream first-word-fall-through FIFO and presents
// them, in order, on a valid/ready output. A two-entry buffer lets the pop strobe
// be computed without looking at out_ready while still sustaining one word/cycle.
// Ports:
//   clk, reset       - clock, synchronous active-high reset
//   enable           - permit popping from the FIFO
//   clr_underrun     - clear the sticky underrun flag (wins over a set)
//   fifo_empty       - upstream FIFO empty flag
//   fifo_r_data      - upstream FIFO head word
//   fifo_rd          - pop strobe to the upstream FIFO
//   out_ready        - downstream accepts a word
//   out_valid        - out_data holds a valid word
//   out_data         - oldest buffered word
//   underrun         - sticky: consumer ready while nothing was available
//   xfer_count       - completed output transfers, wraps silently

module fifo_drain
    import lab5_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clr_underrun,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_r_data,
    output logic                  fifo_rd,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  underrun,
    output logic [CNT_WIDTH-1:0]  xfer_count
);

    occ_state_t            r_state;
    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;
    logic                  r_underrun;
    logic [CNT_WIDTH-1:0]  r_xfer_count;

    occ_state_t            w_next_state;
    logic [DATA_WIDTH-1:0] w_head_nxt;
    logic [DATA_WIDTH-1:0] w_tail_nxt;
    logic                  w_pop;
    logic                  w_xfer;
    logic                  w_underrun_set;

    // Pop only when a slot is guaranteed free regardless of out_ready; reset
    // gates the strobe so a reset never consumes upstream words.
    assign w_pop  = enable & ~fifo_empty & (r_state != S_TWO) & ~reset;
    assign w_xfer = out_valid & out_ready;

    assign w_underrun_set = enable & out_ready & (r_state == S_EMPTY) & fifo_empty;

    assign fifo_rd    = w_pop;
    assign out_valid  = (r_state != S_EMPTY);
    assign out_data   = r_head;
    assign underrun   = r_underrun;
    assign xfer_count = r_xfer_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_EMPTY;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            r_state <= w_next_state;
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
        end
    end

    // r_head is always the oldest word; r_tail only holds the second word in S_TWO.
    always_comb begin
        w_next_state = r_state;
        w_head_nxt   = r_head;
        w_tail_nxt   = r_tail;
        case (r_state)
            S_EMPTY: begin
                if (w_pop) begin
                    w_head_nxt   = fifo_r_data;
                    w_next_state = S_ONE;
                end
            end
            S_ONE: begin
                if (w_pop && w_xfer) begin
                    // Head leaves and the new word takes its place.
                    w_head_nxt = fifo_r_data;
                end else if (w_pop) begin
                    w_tail_nxt   = fifo_r_data;
                    w_next_state = S_TWO;
                end else if (w_xfer) begin
                    w_next_state = S_EMPTY;
                end
            end
            S_TWO: begin
                if (w_xfer) begin
                    w_head_nxt   = r_tail;
                    w_next_state = S_ONE;
                end
            end
            default: begin
                w_next_state = S_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_underrun <= 1'b0;
        end else if (clr_underrun) begin
            r_underrun <= 1'b0;
        end else if (w_underrun_set) begin
            r_underrun <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_xfer_count <= '0;
        end else if (w_xfer) begin
            r_xfer_count <= r_xfer_count + CNT_WIDTH'(1);
        end
    end

endmodule : fifo_drain

// File: tb/tb_fifo_drain.sv
// tb/tb_fifo_drain.sv - directed self-checking bench for fifo_drain

module tb_fifo_drain;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        clr_underrun;
    logic        fifo_empty;
    logic [23:0] fifo_r_data;
    logic        fifo_rd;
    logic        out_ready;
    logic        out_valid;
    logic [23:0] out_data;
    logic        underrun;
    logic [3:0]  xfer_count;

    int cmp_n;
    int err_n;

    // Upstream FWFT FIFO model
    logic [23:0] mem [0:255];
    int          wr_ptr;
    int          rd_ptr;

    // Monitors
    int          pop_cnt;
    int          pop_cyc [0:63];
    int          log_n;
    logic [23:0] log_data [0:63];
    int          log_cyc [0:63];
    int          cyc;
    logic        rd_during_reset;

    assign fifo_empty  = (wr_ptr == rd_ptr);
    assign fifo_r_data = mem[rd_ptr[7:0]];

    fifo_drain #(
        .DATA_WIDTH (24),
        .CNT_WIDTH  (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .clr_underrun (clr_underrun),
        .fifo_empty   (fifo_empty),
        .fifo_r_data  (fifo_r_data),
        .fifo_rd      (fifo_rd),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .underrun     (underrun),
        .xfer_count   (xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset && fifo_rd) rd_during_reset = 1'b1;
        if (fifo_rd) begin
            pop_cyc[pop_cnt % 64] = cyc;
            pop_cnt = pop_cnt + 1;
            rd_ptr <= rd_ptr + 1;
        end
        if (out_valid && out_ready) begin
            log_data[log_n % 64] = out_data;
            log_cyc[log_n % 64]  = cyc;
            log_n = log_n + 1;
        end
        cyc = cyc + 1;
    end

    task automatic push(input logic [23:0] v);
        mem[wr_ptr[7:0]] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset        = 1'b1;
        enable       = 1'b0;
        out_ready    = 1'b0;
        clr_underrun = 1'b0;
        repeat (2) @(negedge clk);
        wr_ptr = rd_ptr;
        reset  = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset     = 1'b1;
        enable    = 1'b1;
        out_ready = 1'b1;
        push(24'h111111);
        @(negedge clk);
        @(negedge clk);
        cmp_n++; if (fifo_rd !== 1'b0) begin err_n++; $display("FAIL reset_fifo_rd: got %b expected 0", fifo_rd); end
        cmp_n++; if (out_valid !== 1'b0) begin err_n++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        cmp_n++; if (out_data !== 24'h0) begin err_n++; $display("FAIL reset_out_data: got %h expected 000000", out_data); end
        cmp_n++; if (underrun !== 1'b0) begin err_n++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
        cmp_n++; if (xfer_count !== 4'd0) begin err_n++; $display("FAIL reset_xfer_count: got %0d expected 0", xfer_count); end
        enable    = 1'b0;
        out_ready = 1'b0;
        wr_ptr    = rd_ptr;
        reset     = 1'b0;
    endtask

    task automatic test_streaming();
        int lb, pb;
        apply_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push(24'(i));
        lb = log_n;
        pb = pop_cnt;
        enable = 1'b1;
        repeat (10) @(negedge clk);
        cmp_n++; if (log_n - lb !== 8) begin err_n++; $display("FAIL stream_count: got %0d expected 8", log_n - lb); end
        for (int i = 0; i < 8; i++) begin
            cmp_n++;
            if (log_data[(lb + i) % 64] !== 24'(i + 1)) begin
                err_n++; $display("FAIL stream_word%0d: got %h expected %h", i, log_data[(lb + i) % 64], 24'(i + 1));
            end
            cmp_n++;
            if (log_cyc[(lb + i) % 64] !== pop_cyc[pb % 64] + 1 + i) begin
                err_n++; $display("FAIL stream_cycle%0d: got %0d expected %0d", i, log_cyc[(lb + i) % 64], pop_cyc[pb % 64] + 1 + i);
            end
        end
        cmp_n++; if (xfer_count !== 4'd8) begin err_n++; $display("FAIL stream_xfer_count: got %0d expected 8", xfer_count); end
        cmp_n++; if (fifo_rd !== 1'b0) begin err_n++; $display("FAIL stream_fifo_rd_idle: got %b expected 0", fifo_rd); end
        cmp_n++; if (pop_cnt - pb !== 8) begin err_n++; $display("FAIL stream_pops: got %0d expected 8", pop_cnt - pb); end
        enable = 1'b0;
    endtask

    task automatic test_backpressure();
        int lb, pb;
        logic [23:0] exp_w [0:2];
        exp_w[0] = 24'h9090AB;
        exp_w[1] = 24'h9012CD;
        exp_w[2] = 24'h9034EF;
        apply_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push(exp_w[i]);
        pb = pop_cnt;
        enable = 1'b1;
        repeat (4) @(negedge clk);
        cmp_n++; if (pop_cnt - pb !== 2) begin err_n++; $display("FAIL bp_pops: got %0d expected 2", pop_cnt - pb); end
        cmp_n++; if (fifo_rd !== 1'b0) begin err_n++; $display("FAIL bp_fifo_rd_full: got %b expected 0", fifo_rd); end
        cmp_n++; if (out_valid !== 1'b1) begin err_n++; $display("FAIL bp_out_valid: got %b expected 1", out_valid); end
        cmp_n++; if (out_data !== 24'h9090AB) begin err_n++; $display("FAIL bp_head: got %h expected 9090ab", out_data); end
        repeat (3) @(negedge clk);
        cmp_n++; if (out_data !== 24'h9090AB) begin err_n++; $display("FAIL bp_head_stable: got %h expected 9090ab", out_data); end
        cmp_n++; if (pop_cnt - pb !== 2) begin err_n++; $display("FAIL bp_no_overflow: got %0d expected 2", pop_cnt - pb); end
        lb = log_n;
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        cmp_n++; if (log_n - lb !== 3) begin err_n++; $display("FAIL bp_drain_count: got %0d expected 3", log_n - lb); end
        for (int i = 0; i < 3; i++) begin
            cmp_n++;
            if (log_data[(lb + i) % 64] !== exp_w[i]) begin
                err_n++; $display("FAIL bp_order%0d: got %h expected %h", i, log_data[(lb + i) % 64], exp_w[i]);
            end
        end
        cmp_n++; if (xfer_count !== 4'd3) begin err_n++; $display("FAIL bp_xfer_count: got %0d expected 3", xfer_count); end
        enable = 1'b0;
    endtask

    task automatic test_starvation();
        apply_reset();
        enable       = 1'b1;
        out_ready    = 1'b1;
        clr_underrun = 1'b1;
        @(negedge clk);
        cmp_n++; if (underrun !== 1'b0) begin err_n++; $display("FAIL starve_clr_wins: got %b expected 0", underrun); end
        clr_underrun = 1'b0;
        @(negedge clk);
        cmp_n++; if (underrun !== 1'b1) begin err_n++; $display("FAIL starve_set: got %b expected 1", underrun); end
        repeat (2) @(negedge clk);
        push(24'hABCDEF);
        @(negedge clk);
        cmp_n++; if (underrun !== 1'b1) begin err_n++; $display("FAIL starve_sticky: got %b expected 1", underrun); end
        clr_underrun = 1'b1;
        @(negedge clk);
        cmp_n++; if (underrun !== 1'b0) begin err_n++; $display("FAIL starve_cleared: got %b expected 0", underrun); end
        clr_underrun = 1'b0;
        enable       = 1'b0;
    endtask

    task automatic test_reset_mid();
        int pb;
        apply_reset();
        out_ready = 1'b0;
        push(24'h9056CA);
        push(24'h9078DB);
        push(24'h9011EE);
        pb = pop_cnt;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        cmp_n++; if (out_data !== 24'h9056CA) begin err_n++; $display("FAIL rmid_pre_head: got %h expected 9056ca", out_data); end
        cmp_n++; if (fifo_rd !== 1'b0) begin err_n++; $display("FAIL rmid_pre_full: got %b expected 0", fifo_rd); end
        reset = 1'b1;
        @(negedge clk);
        cmp_n++; if (out_valid !== 1'b0) begin err_n++; $display("FAIL rmid_out_valid: got %b expected 0", out_valid); end
        cmp_n++; if (xfer_count !== 4'd0) begin err_n++; $display("FAIL rmid_xfer_count: got %0d expected 0", xfer_count); end
        cmp_n++; if (fifo_rd !== 1'b0) begin err_n++; $display("FAIL rmid_fifo_rd: got %b expected 0", fifo_rd); end
        @(negedge clk);
        cmp_n++; if (pop_cnt - pb !== 2) begin err_n++; $display("FAIL rmid_pops: got %0d expected 2", pop_cnt - pb); end
        cmp_n++; if (rd_during_reset !== 1'b0) begin err_n++; $display("FAIL rmid_rd_in_reset: got %b expected 0", rd_during_reset); end
        enable = 1'b0;
        wr_ptr = rd_ptr;
        reset  = 1'b0;
    endtask

    task automatic test_wrap_gating();
        int lb, pb;
        apply_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) push(24'h000100 + 24'(i));
        lb = log_n;
        enable = 1'b1;
        repeat (20) @(negedge clk);
        cmp_n++; if (xfer_count !== 4'd1) begin err_n++; $display("FAIL wrap_xfer_count: got %0d expected 1", xfer_count); end
        cmp_n++; if (log_n - lb !== 17) begin err_n++; $display("FAIL wrap_count: got %0d expected 17", log_n - lb); end
        cmp_n++; if (log_data[(lb + 16) % 64] !== 24'h000110) begin err_n++; $display("FAIL wrap_last: got %h expected 000110", log_data[(lb + 16) % 64]); end
        enable = 1'b0;

        apply_reset();
        out_ready = 1'b0;
        push(24'h0000A1);
        push(24'h0000A2);
        pb = pop_cnt;
        lb = log_n;
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        #1;
        cmp_n++; if (fifo_rd !== 1'b0) begin err_n++; $display("FAIL gate_fifo_rd: got %b expected 0", fifo_rd); end
        cmp_n++; if (out_valid !== 1'b1) begin err_n++; $display("FAIL gate_out_valid: got %b expected 1", out_valid); end
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        cmp_n++; if (log_n - lb !== 1) begin err_n++; $display("FAIL gate_drain_count: got %0d expected 1", log_n - lb); end
        cmp_n++; if (log_data[lb % 64] !== 24'h0000A1) begin err_n++; $display("FAIL gate_word: got %h expected 0000a1", log_data[lb % 64]); end
        cmp_n++; if (pop_cnt - pb !== 1) begin err_n++; $display("FAIL gate_pops: got %0d expected 1", pop_cnt - pb); end
        cmp_n++; if (fifo_rd !== 1'b0) begin err_n++; $display("FAIL gate_fifo_rd_after: got %b expected 0", fifo_rd); end
        cmp_n++; if (out_valid !== 1'b0) begin err_n++; $display("FAIL gate_drained: got %b expected 0", out_valid); end
        out_ready = 1'b0;
    endtask

    initial begin
        cmp_n           = 0;
        err_n           = 0;
        wr_ptr          = 0;
        rd_ptr          = 0;
        pop_cnt         = 0;
        log_n           = 0;
        cyc             = 0;
        rd_during_reset = 1'b0;
        reset           = 1'b1;
        enable          = 1'b0;
        clr_underrun    = 1'b0;
        out_ready       = 1'b0;

        test_reset();
        test_streaming();
        test_backpressure();
        test_starvation();
        test_reset_mid();
        test_wrap_gating();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

endmodule : tb_fifo_drain

// File: doc/fifo_drain.md
FIFO_DRAIN -- requirements
Module: fifo_drain

Interface
REQ-001 Parameter: DATA_WIDTH, default 24, sample width in bits.
REQ-002 Parameter: CNT_WIDTH, default 16, width of the transfer counter.
REQ-003 The block SHALL have one clock, clk; reset is synchronous and active-high, named reset.
REQ-004 Ports SHALL be (name  direction  width  meaning):
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- enable  input  1  permit popping from the FIFO
- clr_underrun  input  1  clear the sticky underrun flag
- fifo_empty  input  1  empty flag of the upstream first-word-fall-through FIFO
- fifo_r_data  input  DATA_WIDTH  head word of the upstream FIFO
- fifo_rd  output  1  pop strobe to the upstream FIFO
- out_ready  input  1  downstream can accept a word
- out_valid  output  1  out_data holds a valid word
- out_data  output  DATA_WIDTH  head of the internal buffer
- underrun  output  1  sticky flag: consumer was starved
- xfer_count  output  CNT_WIDTH  number of completed output transfers

Function
REQ-005 The block SHALL hold a 2-entry internal skid buffer with occupancy states S_EMPTY, S_ONE and S_TWO.
REQ-006 fifo_rd SHALL equal enable & ~fifo_empty & (state != S_TWO), with no combinational dependence on out_ready.
REQ-007 A pop SHALL capture fifo_r_data at the same rising edge where fifo_rd is high.
- Latency: the word is on out_data, with out_valid=1, in the cycle after that edge.
REQ-008 A transfer occurs on a rising edge where out_valid & out_ready.
REQ-009 out_valid SHALL be 1 exactly in S_ONE and S_TWO.
REQ-010 out_data SHALL be the oldest buffered word and SHALL be held stable while out_valid & ~out_ready.
REQ-011 Order SHALL be strict FIFO: words leave in the order they were popped, with none dropped or duplicated.
REQ-012 State transitions SHALL be:
- pop without transfer: occupancy +1
- transfer without pop: occupancy -1
- pop with transfer: occupancy unchanged, and the new word queues behind the remaining entry
- neither: hold
REQ-013 When out_ready is held high in S_EMPTY or S_ONE, the block SHALL sustain one transfer per cycle.
REQ-014 In S_TWO with out_ready low, the block SHALL NOT pop, so no overflow is possible.
REQ-015 When enable is deasserted, popping SHALL stop immediately and already-buffered words SHALL still drain normally.
REQ-016 underrun SHALL set on any edge where enable & out_ready & (state==S_EMPTY) & fifo_empty.
REQ-017 underrun SHALL stay set until clr_underrun=1 or reset.
REQ-018 If set and clear conditions coincide, clr_underrun SHALL win.
REQ-019 xfer_count SHALL increment by 1 per transfer and wrap modulo 2^CNT_WIDTH with no flag.
REQ-020 fifo_empty=1 SHALL force fifo_rd=0 regardless of the other inputs.

Reset
REQ-021 On reset the block SHALL set: state=S_EMPTY, out_valid=0, out_data=0, underrun=0, xfer_count=0.
REQ-022 fifo_rd SHALL be 0 during every cycle where reset=1.
REQ-023 A reset asserted mid-operation SHALL discard all buffered words without popping.

Structure
REQ-024 DATA_WIDTH default and the occupancy state enum (S_EMPTY, S_ONE, S_TWO) SHALL live in a shared package, lab5_pkg.
REQ-025 The block SHALL be a single module with no sub-module; the skid registers and FSM are inline.

Verification
REQ-026 Streaming case: FIFO preloaded with 8 words 0x000001..0x000008, enable=1, out_ready=1.
- Required: transfers of 1..8 on consecutive cycles starting one cycle after the first pop.
- Required: xfer_count=8, then fifo_rd=0 once empty.
REQ-027 Backpressure case: out_ready=0 with FIFO holding 0x9090AB, 0x9012CD, 0x9034EF.
- Required: exactly 2 pops, then state=S_TWO, fifo_rd=0, and out_data=0x9090AB held stable.
- After out_ready=1: outputs 0x9090AB, 0x9012CD, 0x9034EF in order.
REQ-028 Starvation case: enable=1, out_ready=1, fifo_empty=1 for 3 cycles.
- Required: underrun=1 after the first edge and still 1 after fifo_empty falls.
- Required: a clr_underrun pulse returns it to 0.
REQ-029 Reset case: reset asserted while in S_TWO holding 0x9056CA, 0x9078DB.
- Required next cycle: out_valid=0, xfer_count=0, and no fifo_rd during reset.
REQ-030 Wrap and gating case: CNT_WIDTH=4 with 17 transfers.
- Required: xfer_count=1.
- Required: enable dropped in S_ONE drains the single word and then fifo_rd stays 0.
